// File: rtl/e_digit_streamer.sv
//------------------------------------------------------------------------------
// e_digit_streamer
//
// Converts the multi-word fixed-point result of the e calculator into an ASCII
// decimal string "<int>.<digits>\n" and streams it one byte at a time over a
// valid/ready interface. Each fractional digit comes from one word-serial x10
// pass over the fraction words (LSW first); the carry out of the top fraction
// word is the digit.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   start       begins a conversion (sampled in IDLE only), latches in_data
//   in_data     WORDS x 16-bit value, word WORDS-1 = integer part, word 0 = LSW
//   busy        high in every state except IDLE
//   done        one-cycle pulse in the final state of a conversion
//   err         integer word > 9; held until the next accepted start
//   dout        ASCII byte
//   dout_valid  dout is valid (depends on state only)
//   dout_ready  downstream accepts dout when high together with dout_valid
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module e_digit_streamer #(
    parameter int unsigned WORDS      = 32,
    parameter int unsigned NUM_DIGITS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in_data [0:WORDS-1],
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready
);

    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 2);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(NUM_DIGITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT,
        S_DOT,
        S_MUL,
        S_EMIT,
        S_EOL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      buf_q [0:WORDS-1];
    logic [15:0]      buf_d [0:WORDS-1];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [19:0]      prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int unsigned i = 0; i < WORDS; i++) begin
                buf_q[i] <= '0;
            end
            idx_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        dout       = 8'h00;
        dout_valid = 1'b0;
        done       = 1'b0;

        // 0xFFFF*10 + 9 = 655359 fits in 20 bits; top nibble is the carry.
        prod = {4'b0, buf_q[idx_q]} * 20'd10 + {16'b0, carry_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    buf_d   = in_data;
                    // err is decided at latch time so it is already high
                    // while the 'E' byte is being presented.
                    err_d   = (in_data[WORDS-1] > 16'd9);
                    cnt_d   = '0;
                    idx_d   = '0;
                    carry_d = '0;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                dout_valid = 1'b1;
                if (buf_q[WORDS-1] <= 16'd9) begin
                    dout = 8'h30 + buf_q[WORDS-1][7:0];
                    if (dout_ready) state_d = S_DOT;
                end else begin
                    dout = 8'h45;
                    if (dout_ready) state_d = S_EOL;
                end
            end
            S_DOT: begin
                dout_valid = 1'b1;
                dout       = 8'h2E;
                if (dout_ready) begin
                    idx_d   = '0;
                    carry_d = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                buf_d[idx_q] = prod[15:0];
                carry_d      = prod[19:16];
                if (idx_q == LAST_IDX) begin
                    state_d = S_EMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_EMIT: begin
                dout_valid = 1'b1;
                dout       = 8'h30 + {4'b0, carry_q};
                if (dout_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    idx_d   = '0;
                    carry_d = '0;
                    state_d = (cnt_d == CNT_END) ? S_EOL : S_MUL;
                end
            end
            S_EOL: begin
                dout_valid = 1'b1;
                dout       = 8'h0A;
                if (dout_ready) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_e_digit_streamer.sv
//------------------------------------------------------------------------------
// tb_e_digit_streamer
//
// Directed bench for e_digit_streamer with WORDS=4, NUM_DIGITS=8. Expected
// byte strings and cycle counts are hand-computed constants.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_e_digit_streamer;

    localparam int unsigned W = 4;
    localparam int unsigned N = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_data [0:W-1];
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    e_digit_streamer #(
        .WORDS      (W),
        .NUM_DIGITS (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one conversion starting just after a rising edge. bp randomises
    // dout_ready (~30 % high); inj pulses start (with different data) in MUL.
    task automatic run_conv(input string tag,
                            input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3,
                            input string exp, input int unsigned exp_cyc,
                            input bit bp, input bit inj, input bit exp_err);
        logic [7:0]  got [$];
        int unsigned cyc      = 0;
        int unsigned done_cyc = 0;
        int unsigned dot_cyc  = 0;
        int unsigned dig1_cyc = 0;
        int unsigned nchk;
        bit          stall    = 1'b0;
        bit          fin      = 1'b0;
        logic [7:0]  held     = 8'h00;

        in_data[0] = w0;
        in_data[1] = w1;
        in_data[2] = w2;
        in_data[3] = w3;
        dout_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (!fin && cyc < 3000) begin
            if (bp) dout_ready = ($urandom_range(0, 99) < 30);
            if (inj) begin
                start = (cyc == 3);
                if (cyc == 3) begin
                    for (int i = 0; i < W; i++) in_data[i] = 16'h0000;
                end
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_eq({tag, "_int_valid"}, {31'b0, dout_valid}, 32'd1);
                check_eq({tag, "_err_at_int"}, {31'b0, err}, {31'b0, exp_err});
            end
            if (stall) begin
                check_eq({tag, "_hold_valid"}, {31'b0, dout_valid}, 32'd1);
                check_eq({tag, "_hold_dout"}, {24'b0, dout}, {24'b0, held});
            end
            stall = dout_valid && !dout_ready;
            held  = dout;
            if (dout_valid && dout_ready) begin
                got.push_back(dout);
                if (got.size() == 2) dot_cyc = cyc;
                if (got.size() == 3) dig1_cyc = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                fin      = 1'b1;
            end
            @(posedge clk); #1;
        end
        start      = 1'b0;
        dout_ready = 1'b1;

        check_eq({tag, "_done_seen"}, {31'b0, fin}, 32'd1);
        check_eq({tag, "_len"}, got.size(), exp.len());
        nchk = (got.size() < exp.len()) ? got.size() : exp.len();
        for (int i = 0; i < int'(nchk); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), {24'b0, got[i]}, {24'b0, exp[i]});
        end
        if (exp_cyc != 0) begin
            check_eq({tag, "_cycles"}, done_cyc, exp_cyc);
            if (exp.len() > 3) begin
                check_eq({tag, "_dot_cycle"}, dot_cyc, 32'd2);
                check_eq({tag, "_dig1_cycle"}, dig1_cyc, 2 + W);
            end
        end
        @(negedge clk);
        check_eq({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        check_eq({tag, "_done_after"}, {31'b0, done}, 32'd0);
        check_eq({tag, "_valid_after"}, {31'b0, dout_valid}, 32'd0);
        check_eq({tag, "_err_after"}, {31'b0, err}, {31'b0, exp_err});
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'b0, done}, 32'd0);
        check_eq({tag, "_err"}, {31'b0, err}, 32'd0);
        check_eq({tag, "_valid"}, {31'b0, dout_valid}, 32'd0);
        check_eq({tag, "_dout"}, {24'b0, dout}, 32'h00);
    endtask

    // Starts an e conversion and asserts rst in a MUL cycle of the 4th digit
    // (digit EMITs land at cycles 6, 10, 14, 18 with ready held high).
    task automatic run_abort();
        int unsigned cyc     = 0;
        int unsigned n_done  = 0;
        int unsigned n_valid = 0;

        in_data[0] = 16'h8AED;
        in_data[1] = 16'h5162;
        in_data[2] = 16'hB7E1;
        in_data[3] = 16'h0002;
        dout_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 15) begin
            @(negedge clk);
            cyc++;
            if (done) n_done++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("abort_rst");
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done) n_done++;
            if (dout_valid || busy) n_valid++;
        end
        check_eq("abort_no_done", n_done, 32'd0);
        check_eq("abort_quiet", n_valid, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < W; i++) in_data[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_conv("e_val", 16'h8AED, 16'h5162, 16'hB7E1, 16'h0002,
                 "2.71828182\n", 36, 1'b0, 1'b0, 1'b0);
        run_conv("half", 16'h0000, 16'h0000, 16'h8000, 16'h0000,
                 "0.50000000\n", 36, 1'b0, 1'b0, 1'b0);
        run_conv("third", 16'h5555, 16'h5555, 16'h5555, 16'h0000,
                 "0.33333333\n", 36, 1'b0, 1'b0, 1'b0);
        run_conv("bp", 16'h8AED, 16'h5162, 16'hB7E1, 16'h0002,
                 "2.71828182\n", 0, 1'b1, 1'b0, 1'b0);
        run_conv("ovf", 16'h0000, 16'h0000, 16'h0000, 16'h000A,
                 "E\n", 3, 1'b0, 1'b0, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("ovf_err_idle", {31'b0, err}, 32'd1);
        @(posedge clk); #1;

        run_conv("err_clr", 16'h8AED, 16'h5162, 16'hB7E1, 16'h0002,
                 "2.71828182\n", 36, 1'b0, 1'b0, 1'b0);
        run_conv("inj_start", 16'h8AED, 16'h5162, 16'hB7E1, 16'h0002,
                 "2.71828182\n", 36, 1'b0, 1'b1, 1'b0);
        run_abort();
        run_conv("after_rst", 16'h8AED, 16'h5162, 16'hB7E1, 16'h0002,
                 "2.71828182\n", 36, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
